ddr_out_lane_ctrl: RTL
======================

Name: ddr_out_lane_ctrl

Overview:
- Sequences one DDR output flop lane (dual-edge register with C0/C1, CE, D0/D1, R/S, sync reset/set priority R>S>CE).
- Accepts parallel words through a valid/ready handshake and emits 2 bits per cycle on D0/D1.
- Frames each burst with a preamble and a postamble, and parks the lane at a fixed idle level via R/S between bursts.
- Sits between the packet datapath and the IO-side DDR flop instance.

Parameters:
- WIDTH, 8, bits per input word; even, >= 4.
- PREAMBLE_CYC, 2, preamble cycles before the first word of a burst; >= 1.
- IDLE_LEVEL, 0, line level held while idle (0 = park with R, 1 = park with S).

Ports:
- C  input  1  clock; rising edge only.
- R  input  1  reset; synchronous, active-high.
- in_data  input  WIDTH  word to serialize.
- in_valid  input  1  in_data valid.
- in_ready  output  1  word accepted on an edge where in_valid & in_ready.
- abort  input  1  synchronous; terminates the current burst.
- ddr_d0  output  1  to DDR flop D0 (C0 edge bit).
- ddr_d1  output  1  to DDR flop D1 (C1 edge bit).
- ddr_ce  output  1  to DDR flop CE.
- ddr_r  output  1  to DDR flop R.
- ddr_s  output  1  to DDR flop S.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- All outputs are registered. State and outputs update on the same rising edge of C; the per-state values below hold for every cycle the FSM is in that state.
- Storage: one holding register (hold, hold_v) plus a WIDTH-bit shift register. in_ready = ~hold_v, a combinational function of a register. An accept sets hold_v.
- Reset (R=1 at an edge), from any state including mid-burst:
  - state=IDLE, hold_v=0, beat count=0, preamble count=0.
  - ddr_d0=ddr_d1=0, ddr_ce=0, ddr_r=~IDLE_LEVEL, ddr_s=IDLE_LEVEL, busy=0.
  - Any word in hold or in the shift register is discarded.
- IDLE: outputs as at reset. When hold_v=1, go to PRE and load the preamble counter with PREAMBLE_CYC-1.
- PRE:
  - Outputs: ddr_d0=1, ddr_d1=0, ddr_ce=1, ddr_r=ddr_s=0.
  - Counter decrements each cycle. At 0, go to SHIFT: move hold into the shift register, clear hold_v, set beat=0.
- SHIFT:
  - Beat k (0..WIDTH/2-1) presents ddr_d0=word[2k], ddr_d1=word[2k+1] (LSB first), ddr_ce=1, ddr_r=ddr_s=0.
  - On the last beat with hold_v=1: reload the shift register from hold, clear hold_v, beat=0, stay in SHIFT. There is no gap between words.
  - On the last beat with hold_v=0: go to POST.
  - Exactly WIDTH/2 cycles per word.
- POST: one cycle of ddr_d0=ddr_d1=IDLE_LEVEL, ddr_ce=1, ddr_r=ddr_s=0. Then:
  - IDLE if hold_v=0;
  - PRE if hold_v=1 (a new burst gets a full preamble).
- abort=1 in PRE or SHIFT: next state POST. The remaining beats of the current word are dropped; hold is kept. abort is ignored in IDLE and POST.
- Simultaneous accept and last beat: the word accepted at that edge lands in hold after the transfer decision, so it is not chained. It starts a new burst via POST→PRE.
- An accept during the POST cycle starts the next burst from PRE.
- Never assert ddr_r and ddr_s together. ddr_ce=0 only in IDLE.
- Beat counter width is clog2(WIDTH/2). It wraps to 0 only by explicit reload, never by overflow.

Test Plan:
- Reset mid-burst (WIDTH=8, PREAMBLE_CYC=2, IDLE_LEVEL=0), assert R during SHIFT beat 1 → next cycle: ddr_r=1, ddr_s=0, ddr_ce=0, busy=0, in_ready=1. No further data beats appear after R is released.
- Single word 8'hB4 accepted in IDLE → PRE for 2 cycles (d0/d1=1/0), then beats d0/d1 = 0/0, 1/0, 1/1, 0/1, then POST 0/0, then IDLE with ddr_r=1.
- Words 8'h0F and 8'hF0 back-to-back, the second accepted during beat 0 of the first → 8 consecutive SHIFT cycles with no gap: 1/1, 1/1, 0/0, 0/0, 0/0, 0/0, 1/1, 1/1. One preamble and one POST total.
- abort during beat 1 of 8'hFF with a second word 8'h81 held → POST next cycle, then PRE×2, then beats 1/0, 0/0, 0/0, 0/1.
- IDLE_LEVEL=1 → at reset ddr_s=1, ddr_r=0. POST drives d0=d1=1. Over the whole run, ddr_r & ddr_s is never observed high together.
- Backpressure: hold in_valid high continuously → in_ready deasserts while hold_v=1. No word is lost or duplicated across 16 random words; the serialized stream matches the inputs LSB first.

Source files
------------

// File: rtl/ddr_out_lane_ctrl.sv
// Sequencer for one DDR output flop lane: serializes parallel words two bits per
// cycle, frames each burst with preamble/postamble and parks the lane via R/S when idle.
module ddr_out_lane_ctrl #(
  parameter int WIDTH        = 8,
  parameter int PREAMBLE_CYC = 2,
  parameter bit IDLE_LEVEL   = 1'b0
) (
  input  logic             C,
  input  logic             R,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             abort,
  output logic             ddr_d0,
  output logic             ddr_d1,
  output logic             ddr_ce,
  output logic             ddr_r,
  output logic             ddr_s,
  output logic             busy
);

  localparam int BEATS = WIDTH / 2;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PW    = (PREAMBLE_CYC > 1) ? $clog2(PREAMBLE_CYC) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [PW-1:0] PRE_LOAD  = PW'(PREAMBLE_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_SHIFT, S_POST} state_t;

  typedef struct packed {
    logic d0;
    logic d1;
    logic ce;
    logic r;
    logic s;
    logic busy;
  } lane_out_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] hold, sh, sh_n;
  logic             hold_v;
  logic [BW-1:0]    beat, beat_n;
  logic [PW-1:0]    pre_cnt, pre_cnt_n;
  logic             xfer, acc;
  lane_out_t        out_q, out_n;

  assign in_ready = ~hold_v;
  assign acc      = in_valid & ~hold_v;

  // state register, datapath registers and registered lane outputs
  always_ff @(posedge C) begin
    if (R) begin
      state   <= S_IDLE;
      hold    <= '0;
      hold_v  <= 1'b0;
      sh      <= '0;
      beat    <= '0;
      pre_cnt <= '0;
      out_q   <= '{d0: 1'b0, d1: 1'b0, ce: 1'b0, r: ~IDLE_LEVEL, s: IDLE_LEVEL, busy: 1'b0};
    end else begin
      state   <= state_n;
      sh      <= sh_n;
      beat    <= beat_n;
      pre_cnt <= pre_cnt_n;
      out_q   <= out_n;
      if (acc) hold <= in_data;
      // transfer is decided on the old hold_v, so a same-edge accept is never chained
      hold_v  <= (hold_v & ~xfer) | acc;
    end
  end

  // next-state and datapath sequencing
  always_comb begin
    state_n   = state;
    sh_n      = sh;
    beat_n    = beat;
    pre_cnt_n = pre_cnt;
    xfer      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (hold_v) begin
          state_n   = S_PRE;
          pre_cnt_n = PRE_LOAD;
        end
      end
      S_PRE: begin
        if (abort) begin
          state_n = S_POST;
        end else if (pre_cnt == '0) begin
          state_n = S_SHIFT;
          xfer    = 1'b1;
          sh_n    = hold;
          beat_n  = '0;
        end else begin
          pre_cnt_n = pre_cnt - PW'(1);
        end
      end
      S_SHIFT: begin
        if (abort) begin
          state_n = S_POST;
        end else if (beat == LAST_BEAT) begin
          if (hold_v) begin
            xfer   = 1'b1;
            sh_n   = hold;
            beat_n = '0;
          end else begin
            state_n = S_POST;
          end
        end else begin
          beat_n = beat + BW'(1);
          sh_n   = {2'b00, sh[WIDTH-1:2]};
        end
      end
      S_POST: begin
        if (hold_v) begin
          state_n   = S_PRE;
          pre_cnt_n = PRE_LOAD;
        end else begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // outputs decoded from the upcoming state so they land with it on the same edge
  always_comb begin
    out_n = '{d0: 1'b0, d1: 1'b0, ce: 1'b0, r: ~IDLE_LEVEL, s: IDLE_LEVEL, busy: 1'b0};
    unique case (state_n)
      S_PRE: begin
        out_n = '{d0: 1'b1, d1: 1'b0, ce: 1'b1, r: 1'b0, s: 1'b0, busy: 1'b1};
      end
      S_SHIFT: begin
        out_n = '{d0: sh_n[0], d1: sh_n[1], ce: 1'b1, r: 1'b0, s: 1'b0, busy: 1'b1};
      end
      S_POST: begin
        out_n = '{d0: IDLE_LEVEL, d1: IDLE_LEVEL, ce: 1'b1, r: 1'b0, s: 1'b0, busy: 1'b1};
      end
      default: ;
    endcase
  end

  assign ddr_d0 = out_q.d0;
  assign ddr_d1 = out_q.d1;
  assign ddr_ce = out_q.ce;
  assign ddr_r  = out_q.r;
  assign ddr_s  = out_q.s;
  assign busy   = out_q.busy;

endmodule
